// File: rtl/reg_file_cc_if.sv
// Bus-side signal bundle for reg_file_cc: write port, two read ports,
// condition-code load and the pending-write scoreboard.
interface reg_file_cc_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             LD_REG;
    logic [AW-1:0]    DR;
    logic [WIDTH-1:0] bus_in;
    logic             LD_CC;
    logic [AW-1:0]    SR1;
    logic [AW-1:0]    SR2;
    logic [WIDTH-1:0] SR1_out;
    logic [WIDTH-1:0] SR2_out;
    logic             N;
    logic             Z;
    logic             P;
    logic             mark_valid;
    logic [AW-1:0]    mark_idx;
    logic [DEPTH-1:0] busy;

    modport master (
        output LD_REG, DR, bus_in, LD_CC, SR1, SR2, mark_valid, mark_idx,
        input  SR1_out, SR2_out, N, Z, P, busy
    );

    modport slave (
        input  LD_REG, DR, bus_in, LD_CC, SR1, SR2, mark_valid, mark_idx,
        output SR1_out, SR2_out, N, Z, P, busy
    );
endinterface

// File: rtl/reg_file_cc.sv
// DEPTH x WIDTH register file (1W/2R, optional write-to-read bypass) with
// NZP condition-code register and a per-register pending-write scoreboard.
module reg_file_cc #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter bit BYPASS = 1'b1
) (
    input logic          Clk,
    input logic          Reset,
    reg_file_cc_if.slave rf
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;
    logic             n_reg;
    logic             z_reg;
    logic             p_reg;
    logic             dr_ok;
    logic             sr1_ok;
    logic             sr2_ok;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             flag_n;
    logic             flag_z;

    // Index range checks only matter when DEPTH is not a power of two.
    assign dr_ok  = {1'b0, rf.DR}  < DEPTH_W;
    assign sr1_ok = {1'b0, rf.SR1} < DEPTH_W;
    assign sr2_ok = {1'b0, rf.SR2} < DEPTH_W;

    assign flag_n = rf.bus_in[WIDTH-1];
    assign flag_z = (rf.bus_in == '0);

    // Set (issue) wins over clear (writeback) on the same index.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_busy
            assign busy_next[gi] =
                (rf.mark_valid && rf.mark_idx == AW'(gi)) ? 1'b1 :
                (rf.LD_REG     && rf.DR       == AW'(gi)) ? 1'b0 :
                busy_reg[gi];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
            busy_reg <= '0;
            n_reg    <= 1'b0;
            z_reg    <= 1'b0;
            p_reg    <= 1'b0;
        end else begin
            if (rf.LD_REG && dr_ok) begin
                regs_reg[rf.DR] <= rf.bus_in;
            end
            busy_reg <= busy_next;
            if (rf.LD_CC) begin
                n_reg <= flag_n;
                z_reg <= flag_z;
                p_reg <= !flag_n && !flag_z;
            end
        end
    end

    always_comb begin
        rd1 = '0;
        if (sr1_ok) begin
            rd1 = regs_reg[rf.SR1];
        end
        if (BYPASS && rf.LD_REG && dr_ok && rf.DR == rf.SR1) begin
            rd1 = rf.bus_in;
        end
    end

    always_comb begin
        rd2 = '0;
        if (sr2_ok) begin
            rd2 = regs_reg[rf.SR2];
        end
        if (BYPASS && rf.LD_REG && dr_ok && rf.DR == rf.SR2) begin
            rd2 = rf.bus_in;
        end
    end

    assign rf.SR1_out = rd1;
    assign rf.SR2_out = rd2;
    assign rf.N       = n_reg;
    assign rf.Z       = z_reg;
    assign rf.P       = p_reg;
    assign rf.busy    = busy_reg;
endmodule

// File: tb/tb_reg_file_cc.sv
// Directed bench for reg_file_cc: instance a (8 regs, bypass on) and
// instance b (6 regs, bypass off) for the non-bypass and out-of-range cases.
module tb_reg_file_cc;
    logic Clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 Clk = ~Clk;

    reg_file_cc_if #(.WIDTH(16), .DEPTH(8)) a_if ();
    reg_file_cc_if #(.WIDTH(16), .DEPTH(6)) b_if ();

    reg_file_cc #(.WIDTH(16), .DEPTH(8), .BYPASS(1'b1)) dut_a (
        .Clk   (Clk),
        .Reset (Reset),
        .rf    (a_if)
    );

    reg_file_cc #(.WIDTH(16), .DEPTH(6), .BYPASS(1'b0)) dut_b (
        .Clk   (Clk),
        .Reset (Reset),
        .rf    (b_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        a_if.LD_REG = 0; a_if.DR = 0; a_if.bus_in = 0; a_if.LD_CC = 0;
        a_if.SR1 = 0; a_if.SR2 = 0; a_if.mark_valid = 0; a_if.mark_idx = 0;
        b_if.LD_REG = 0; b_if.DR = 0; b_if.bus_in = 0; b_if.LD_CC = 0;
        b_if.SR1 = 0; b_if.SR2 = 0; b_if.mark_valid = 0; b_if.mark_idx = 0;
    endtask

    function automatic logic [31:0] nzp_a();
        return {29'd0, a_if.N, a_if.Z, a_if.P};
    endfunction

    initial begin
        Reset = 1'b1;
        idle();

        // Reset held two cycles with write, CC load and issue all requested.
        a_if.LD_REG = 1; a_if.DR = 1; a_if.bus_in = 16'hFFFF;
        a_if.LD_CC = 1; a_if.mark_valid = 1; a_if.mark_idx = 1;
        tick();
        tick();
        Reset = 1'b0;
        idle();
        #1;
        for (int i = 0; i < 8; i++) begin
            a_if.SR1 = 3'(i);
            #1;
            check($sformatf("reset_reg%0d", i), 32'(a_if.SR1_out), 32'h0);
        end
        check("reset_nzp", nzp_a(), 32'h0);
        check("reset_busy", 32'(a_if.busy), 32'h0);

        // Write then read on both ports.
        a_if.LD_REG = 1; a_if.DR = 3; a_if.bus_in = 16'hBEEF;
        tick();
        idle();
        a_if.SR1 = 3; a_if.SR2 = 3;
        #1;
        check("wr_sr1", 32'(a_if.SR1_out), 32'hBEEF);
        check("wr_sr2", 32'(a_if.SR2_out), 32'hBEEF);
        a_if.SR1 = 2; a_if.SR2 = 4;
        #1;
        check("wr_other_sr1", 32'(a_if.SR1_out), 32'h0);
        check("wr_other_sr2", 32'(a_if.SR2_out), 32'h0);

        // Bypass on a, no bypass on b.
        a_if.LD_REG = 1; a_if.DR = 5; a_if.bus_in = 16'h1234; a_if.SR1 = 5; a_if.SR2 = 3;
        b_if.LD_REG = 1; b_if.DR = 5; b_if.bus_in = 16'h1234; b_if.SR1 = 5;
        #1;
        check("bypass_a_same", 32'(a_if.SR1_out), 32'h1234);
        check("bypass_a_port2", 32'(a_if.SR2_out), 32'hBEEF);
        check("nobypass_b_same", 32'(b_if.SR1_out), 32'h0);
        tick();
        idle();
        a_if.SR1 = 5; b_if.SR1 = 5;
        #1;
        check("bypass_a_next", 32'(a_if.SR1_out), 32'h1234);
        check("nobypass_b_next", 32'(b_if.SR1_out), 32'h1234);

        // Condition codes.
        a_if.LD_CC = 1; a_if.bus_in = 16'h8000;
        tick();
        check("cc_neg", nzp_a(), 32'h4);
        a_if.bus_in = 16'h0000;
        tick();
        check("cc_zero", nzp_a(), 32'h2);
        a_if.bus_in = 16'h0001;
        tick();
        check("cc_pos", nzp_a(), 32'h1);
        a_if.LD_CC = 0; a_if.bus_in = 16'h8000;
        tick();
        check("cc_hold", nzp_a(), 32'h1);
        idle();

        // Scoreboard set, set-beats-clear, clear, and write to a non-busy reg.
        a_if.mark_valid = 1; a_if.mark_idx = 2;
        tick();
        check("sb_set", 32'(a_if.busy), 32'h04);
        a_if.LD_REG = 1; a_if.DR = 2;
        tick();
        check("sb_set_wins", 32'(a_if.busy), 32'h04);
        a_if.mark_valid = 0;
        tick();
        check("sb_clear", 32'(a_if.busy), 32'h00);
        a_if.DR = 6;
        tick();
        check("sb_nonbusy_write", 32'(a_if.busy), 32'h00);
        idle();

        // Out-of-range indices on the 6-deep instance.
        b_if.LD_REG = 1; b_if.DR = 6; b_if.bus_in = 16'h5555;
        b_if.mark_valid = 1; b_if.mark_idx = 6;
        tick();
        check("oor_mark_ignored", 32'(b_if.busy), 32'h0);
        b_if.LD_REG = 0; b_if.mark_idx = 5;
        b_if.SR1 = 6; b_if.SR2 = 7;
        #1;
        check("oor_read6", 32'(b_if.SR1_out), 32'h0);
        check("oor_read7", 32'(b_if.SR2_out), 32'h0);
        tick();
        check("inrange_mark5", 32'(b_if.busy), 32'h20);
        idle();

        // Reset mid-operation.
        a_if.LD_REG = 1; a_if.DR = 7; a_if.bus_in = 16'hAAAA;
        a_if.mark_valid = 1; a_if.mark_idx = 7;
        tick();
        idle();
        a_if.LD_CC = 1; a_if.bus_in = 16'h0001;
        tick();
        idle();
        a_if.SR1 = 7;
        #1;
        check("pre_rst_reg7", 32'(a_if.SR1_out), 32'hAAAA);
        check("pre_rst_busy", 32'(a_if.busy), 32'h80);
        check("pre_rst_nzp", nzp_a(), 32'h1);
        Reset = 1'b1;
        a_if.LD_REG = 1; a_if.DR = 7; a_if.bus_in = 16'hFFFF;
        a_if.LD_CC = 1; a_if.mark_valid = 1; a_if.mark_idx = 4;
        tick();
        Reset = 1'b0;
        idle();
        a_if.SR1 = 7; a_if.SR2 = 3;
        #1;
        check("post_rst_reg7", 32'(a_if.SR1_out), 32'h0);
        check("post_rst_reg3", 32'(a_if.SR2_out), 32'h0);
        check("post_rst_busy", 32'(a_if.busy), 32'h0);
        check("post_rst_nzp", nzp_a(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
